// File: rtl/tilemap_column_streamer.sv
// +--------------------------------------------------------------------------+
// | tilemap_column_streamer: streams level tiles into the tilemap wrap ring,   |
// | one ROWS-tall column at a time, ahead of the horizontal scroll. Rev 1.0    |
// +--------------------------------------------------------------------------+
`default_nettype none

module tilemap_column_streamer #(
  parameter int ROWS      = 15,
  parameter int MAP_COLS  = 32,
  parameter int LOOKAHEAD = 21
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        frame_start,
  input  logic [9:0]  scroll_offset,
  input  logic [7:0]  lvl_data,
  input  logic        lvl_valid,
  output logic        lvl_ready,
  output logic [13:0] tm_address,
  output logic        tm_we,
  output logic [7:0]  tm_din,
  output logic        busy,
  output logic        underrun
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_WAIT    = 2'd2,
    ST_FILL    = 2'd3
  } state_t;

  localparam logic [5:0] C_COL_MASK    = 6'(MAP_COLS - 1);
  localparam logic [3:0] C_ROW_LAST    = 4'(ROWS - 1);
  localparam logic [5:0] C_LA_COL      = 6'(LOOKAHEAD);
  localparam logic [5:0] C_PREFILL_END = 6'((LOOKAHEAD + 1) % MAP_COLS);

  state_t      state_q, state_d;
  logic [3:0]  row_q, row_d;
  logic [5:0]  col_ptr_q, col_ptr_d;
  logic [5:0]  end_col_q, end_col_d;
  logic        underrun_q, underrun_d;
  logic        tm_we_q, tm_we_d;
  logic [7:0]  tm_din_q, tm_din_d;
  logic [13:0] tm_address_q, tm_address_d;

  logic        w_active;
  logic        w_accept;
  logic [5:0]  w_col_next;
  logic [5:0]  w_target;
  logic        unused_scroll_fine;

  assign unused_scroll_fine = ^scroll_offset[4:0];

  assign w_active   = (state_q == ST_PREFILL) || (state_q == ST_FILL);
  assign w_accept   = lvl_valid && w_active;
  assign w_col_next = (col_ptr_q + 6'd1) & C_COL_MASK;
  // Target column kept LOOKAHEAD+1 ahead of the leftmost visible tile.
  assign w_target   = ({1'b0, scroll_offset[9:5]} + C_LA_COL + 6'd1) & C_COL_MASK;

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_ptr_d    = col_ptr_q;
    end_col_d    = end_col_q;
    underrun_d   = underrun_q;
    tm_we_d      = 1'b0;
    tm_din_d     = tm_din_q;
    tm_address_d = tm_address_q;

    if (start) begin
      // A beat arriving with start belongs to the dropped column.
      row_d      = 4'd0;
      col_ptr_d  = 6'd0;
      underrun_d = 1'b0;
      state_d    = ST_PREFILL;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (frame_start) begin
            end_col_d = w_target;
            if (w_target != col_ptr_q) begin
              state_d = ST_FILL;
            end
          end
        end
        ST_PREFILL, ST_FILL: begin
          if (state_q == ST_FILL && frame_start) begin
            end_col_d  = w_target;
            underrun_d = 1'b1;
          end
          if (w_accept) begin
            tm_we_d      = 1'b1;
            tm_din_d     = lvl_data;
            tm_address_d = {4'b0000, row_q, col_ptr_q};
            if (row_q == C_ROW_LAST) begin
              row_d     = 4'd0;
              col_ptr_d = w_col_next;
              if (state_q == ST_PREFILL) begin
                if (col_ptr_q == C_LA_COL) begin
                  end_col_d = C_PREFILL_END;
                  state_d   = ST_WAIT;
                end
              end else if (w_col_next == end_col_d) begin
                state_d = ST_WAIT;
              end
            end else begin
              row_d = row_q + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      row_q        <= 4'd0;
      col_ptr_q    <= 6'd0;
      end_col_q    <= 6'd0;
      underrun_q   <= 1'b0;
      tm_we_q      <= 1'b0;
      tm_din_q     <= 8'd0;
      tm_address_q <= 14'd0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_ptr_q    <= col_ptr_d;
      end_col_q    <= end_col_d;
      underrun_q   <= underrun_d;
      tm_we_q      <= tm_we_d;
      tm_din_q     <= tm_din_d;
      tm_address_q <= tm_address_d;
    end
  end

  assign lvl_ready  = w_active;
  assign busy       = w_active;
  assign underrun   = underrun_q;
  assign tm_we      = tm_we_q;
  assign tm_din     = tm_din_q;
  assign tm_address = tm_address_q;

endmodule

`default_nettype wire

// File: tb/tb_tilemap_column_streamer.sv
// Directed bench for tilemap_column_streamer: prefill, fills, wrap, backpressure, underrun, reset.
`default_nettype none

module tb_tilemap_column_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        frame_start;
  logic [9:0]  scroll_offset;
  logic [7:0]  lvl_data;
  logic        lvl_valid;
  logic        lvl_ready;
  logic [13:0] tm_address;
  logic        tm_we;
  logic [7:0]  tm_din;
  logic        busy;
  logic        underrun;

  int checks = 0;
  int errors = 0;
  int data_cnt = 0;
  int base;

  typedef struct {
    logic [13:0] a;
    logic [7:0]  d;
  } wr_t;
  wr_t wq[$];

  always #5 clk = ~clk;

  tilemap_column_streamer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .frame_start   (frame_start),
    .scroll_offset (scroll_offset),
    .lvl_data      (lvl_data),
    .lvl_valid     (lvl_valid),
    .lvl_ready     (lvl_ready),
    .tm_address    (tm_address),
    .tm_we         (tm_we),
    .tm_din        (tm_din),
    .busy          (busy),
    .underrun      (underrun)
  );

  always @(negedge clk) begin
    if (tm_we === 1'b1) wq.push_back('{tm_address, tm_din});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; the source presents a running byte count, stepped per accepted beat.
  task automatic tick();
    logic acc;
    acc = (lvl_valid === 1'b1) && (lvl_ready === 1'b1);
    @(negedge clk);
    if (acc) data_cnt++;
    lvl_data = data_cnt[7:0];
  endtask

  task automatic run_until_idle(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (busy === 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
    tick();
  endtask

  task automatic check_cols(input string tag, input int first_data, input int first_col, input int ncols);
    chk({tag, "_count"}, wq.size(), ncols * 15);
    if (wq.size() == ncols * 15) begin
      for (int i = 0; i < ncols * 15; i++) begin
        int c;
        int r;
        int d;
        c = (first_col + i / 15) % 32;
        r = i % 15;
        d = (first_data + i) % 256;
        chk({tag, "_addr"}, {18'd0, wq[i].a}, r * 64 + c);
        chk({tag, "_din"}, {24'd0, wq[i].d}, d);
      end
    end
    wq.delete();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    frame_start = 1'b0;
    scroll_offset = 10'd0;
    lvl_valid = 1'b0;
    lvl_data = 8'd0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    chk("rst_we", {31'd0, tm_we}, 32'd0);
    chk("rst_addr", {18'd0, tm_address}, 32'd0);
    chk("rst_din", {24'd0, tm_din}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, lvl_ready}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);

    // frame_start while idle does nothing
    frame_start = 1'b1; scroll_offset = 10'd32; lvl_valid = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    wq.delete();

    // Prefill columns 0..21
    base = data_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("prefill_busy", {31'd0, busy}, 32'd1);
    chk("prefill_ready", {31'd0, lvl_ready}, 32'd1);
    while (busy === 1'b1 && data_cnt < 400) tick();
    chk("prefill_last_we", {31'd0, tm_we}, 32'd1);
    chk("prefill_last_addr", {18'd0, tm_address}, 32'd917);
    chk("prefill_beats", data_cnt - base, 330);
    tick();
    chk("wait_ready", {31'd0, lvl_ready}, 32'd0);
    if (wq.size() > 0) chk("prefill_first_addr", {18'd0, wq[0].a}, 32'd0);
    check_cols("prefill", base, 0, 22);

    // Single step: scroll 32 -> column 22
    base = data_cnt;
    scroll_offset = 10'd32; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("fill_busy", {31'd0, busy}, 32'd1);
    run_until_idle("step_timeout", 100);
    check_cols("step", base, 22, 1);

    // Restart, then multi-column jump: scroll 96 -> columns 22,23,24
    start = 1'b1;
    tick();
    start = 1'b0;
    run_until_idle("reprefill_timeout", 500);
    wq.delete();
    base = data_cnt;
    scroll_offset = 10'd96; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    run_until_idle("jump_timeout", 200);
    check_cols("jump", base, 22, 3);

    // Wrap: scroll 352 -> end_col 1; columns 25..31 then 0
    base = data_cnt;
    scroll_offset = 10'd352; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    run_until_idle("wrap_timeout", 300);
    check_cols("wrap", base, 25, 8);

    // col_ptr is now 1: scroll 384 -> exactly column 1
    base = data_cnt;
    scroll_offset = 10'd384; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    run_until_idle("after_wrap_timeout", 100);
    check_cols("after_wrap", base, 1, 1);

    // Backpressure: lvl_valid toggles every cycle, column 2
    base = data_cnt;
    scroll_offset = 10'd416; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int n = 0; n < 200 && busy === 1'b1; n++) begin
      lvl_valid = ~lvl_valid;
      tick();
    end
    chk("bp_timeout", {31'd0, busy}, 32'd0);
    lvl_valid = 1'b1;
    tick();
    chk("bp_beats", data_cnt - base, 15);
    check_cols("bp", base, 2, 1);
    chk("no_underrun_yet", {31'd0, underrun}, 32'd0);

    // Underrun: stall mid-column 3, frame_start arrives
    base = data_cnt;
    scroll_offset = 10'd448; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (4) tick();
    lvl_valid = 1'b0;
    repeat (3) tick();
    chk("stall_busy", {31'd0, busy}, 32'd1);
    chk("stall_no_underrun", {31'd0, underrun}, 32'd0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    chk("underrun_set", {31'd0, underrun}, 32'd1);
    lvl_valid = 1'b1;
    run_until_idle("underrun_timeout", 100);
    chk("underrun_sticky", {31'd0, underrun}, 32'd1);
    check_cols("underrun_col", base, 3, 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    chk("caught_up_busy", {31'd0, busy}, 32'd0);
    chk("underrun_sticky2", {31'd0, underrun}, 32'd1);

    // start clears underrun; reset mid-column zeroes everything
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_clears_underrun", {31'd0, underrun}, 32'd0);
    repeat (5) tick();
    chk("mid_prefill_we", {31'd0, tm_we}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_we", {31'd0, tm_we}, 32'd0);
    chk("reset_addr", {18'd0, tm_address}, 32'd0);
    chk("reset_din", {24'd0, tm_din}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_ready", {31'd0, lvl_ready}, 32'd0);
    chk("reset_underrun", {31'd0, underrun}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
